// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder serving an internal word-organised scratch SRAM.
// Supports the pipelined address/data-phase protocol, a fixed number of wait
// states per OKAY transfer, byte/halfword/word writes on the proper byte
// lanes, and the two-cycle ERROR response for illegal or out-of-range
// transfers.
//
// Parameters
//   MEM_WORDS    number of 32-bit words (byte addresses 0 .. 4*MEM_WORDS-1)
//   WAIT_STATES  wait cycles inserted per OKAY transfer (0..3)
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   hsel        in   slave select from the decoder
//   haddr       in   byte address (address phase)
//   htrans      in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite      in   1 = write, 0 = read
//   hsize       in   000 byte, 001 halfword, 010 word
//   hprot       in   protection attributes (ignored)
//   hwdata      in   write data (data phase)
//   hready_in   in   bus-wide hready from the mux
//   hrdata      out  read data, full word during the completion cycle
//   hready_out  out  this slave's hready
//   hresp       out  0 = OKAY, 1 = ERROR
// ----------------------------------------------------------------------------
module ahb_sram_slave #(
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [3:0]  hprot,
   input  logic [31:0] hwdata,
   input  logic        hready_in,
   output logic [31:0] hrdata,
   output logic        hready_out,
   output logic        hresp
);

   localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
   // Counter load value; only meaningful when WAIT_STATES > 0.
   localparam logic [1:0]  WS_LOAD   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;
   logic [31:0]     mem_q [MEM_WORDS];

   logic            accept;
   logic            commit;
   logic [3:0]      lane_en;
   logic [AW-1:0]   word_idx;

   logic            unused_ok;
   assign unused_ok = ^{hprot, htrans[0]};

   // Any illegal size, misalignment or out-of-range word turns the transfer
   // into an ERROR response without touching memory.
   function automatic logic is_illegal(input logic [31:0] a, input logic [2:0] sz);
      logic bad;
      bad = 1'b0;
      if (sz > 3'b010)                           bad = 1'b1;
      if ((sz == 3'b001) && a[0])                bad = 1'b1;
      if ((sz == 3'b010) && (a[1:0] != 2'b00))   bad = 1'b1;
      if ({2'b00, a[31:2]} >= MEM_LIMIT)         bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] m;
      case (sz)
         2'b00:   m = 4'b0001 << a;
         2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // New address phases are only taken when no data phase is stalling.
   assign accept   = hsel && hready_in && htrans[1] &&
                     ((state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2));
   assign commit   = (state_q == S_DATA) && write_q;
   assign lane_en  = lane_mask(size_q, addr_q[1:0]);
   assign word_idx = addr_q[AW+1:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      write_d    = write_q;
      size_d     = size_q;
      hready_out = 1'b1;
      hresp      = 1'b0;
      hrdata     = '0;

      case (state_q)
         S_WAIT: begin
            hready_out = 1'b0;
            if (cnt_q == 2'd0) state_d = S_DATA;
            else               cnt_d   = cnt_q - 2'd1;
         end
         S_ERR1: begin
            hready_out = 1'b0;
            hresp      = 1'b1;
            state_d    = S_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all open a new address phase the same way.
            if (state_q == S_DATA) hrdata = mem_q[word_idx];
            if (state_q == S_ERR2) hresp  = 1'b1;
            if (state_q != S_IDLE) state_d = S_IDLE;
            if (accept) begin
               addr_d  = haddr[AW+1:0];
               write_d = hwrite;
               size_d  = hsize[1:0];
               if (is_illegal(haddr, hsize)) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
      endcase
   end

   // Writes land on the edge that ends DATA, so a back-to-back read's DATA
   // cycle already sees the updated word through the combinational read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      end else if (commit) begin
         for (int l = 0; l < 4; l++) begin
            if (lane_en[l]) mem_q[word_idx][8*l +: 8] <= hwdata[8*l +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, hsel, hwrite, sel, hold_low;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [3:0]  hprot;

   logic [31:0] hrdata1, hrdata0;
   logic        hready1, hready0, hresp1, hresp0;
   logic        hsel1, hsel0;
   logic        hrdy_bus, hresp_bus, hrdy_in;
   logic [31:0] hrdata_bus;

   // sel = 0 targets the WAIT_STATES=1 instance, sel = 1 the zero-wait one.
   assign hsel1      = hsel & ~sel;
   assign hsel0      = hsel & sel;
   assign hrdy_bus   = sel ? hready0 : hready1;
   assign hresp_bus  = sel ? hresp0  : hresp1;
   assign hrdata_bus = sel ? hrdata0 : hrdata1;
   assign hrdy_in    = hold_low ? 1'b0 : hrdy_bus;

   ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset(reset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
      .hready_in(hrdy_in), .hrdata(hrdata1), .hready_out(hready1), .hresp(hresp1)
   );

   ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
      .hready_in(hrdy_in), .hrdata(hrdata0), .hready_out(hready0), .hresp(hresp0)
   );

   typedef struct {
      string       name;
      logic        resp;
      int          waits;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, want);
   endtask

   task automatic chk1(input string nm, input logic got, input logic want);
      chk(nm, {31'd0, got}, {31'd0, want});
   endtask

   // Drive one address phase, wait for it to be accepted, then present the
   // data-phase write data and release the address bus.
   task automatic xfer(input string nm, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input logic resp,
                       input int waits, input logic chk_rd, input logic [31:0] rd,
                       input logic push);
      logic ok;
      ok     = 1'b0;
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      haddr  = a;
      hsize  = sz;
      if (push) exp_q.push_back('{nm, resp, waits, chk_rd, rd});
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = hrdy_in;
      end
      if (!ok) chk1({nm, " addr_phase_hready"}, hrdy_in, 1'b1);
      @(posedge clk);
      #1;
      hwdata = wd;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   task automatic wr(input string nm, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input int waits);
      xfer(nm, 1'b1, a, sz, wd, 1'b0, waits, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] expd, input int waits);
      xfer(nm, 1'b0, a, sz, 32'h0, 1'b0, waits, 1'b1, expd, 1'b1);
   endtask

   task automatic err(input string nm, input logic w, input logic [31:0] a, input logic [2:0] sz);
      xfer(nm, w, a, sz, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, 32'h0, 1'b1);
   endtask

   // Monitor: follows every accepted address phase into its data phase and
   // scores the completion against the oldest expected response.
   initial begin : monitor
      bit   dphase;
      int   waits;
      int   low_err;
      exp_t e;
      dphase  = 1'b0;
      waits   = 0;
      low_err = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            dphase = 1'b0;
         end else begin
            if (dphase) begin
               if (!hrdy_bus) begin
                  waits++;
                  if (hresp_bus) low_err++;
               end else begin
                  chk1("scoreboard_has_entry", exp_q.size() != 0, 1'b1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     chk1({e.name, " hresp"}, hresp_bus, e.resp);
                     chk({e.name, " wait_cycles"}, 32'(waits), 32'(e.waits));
                     chk({e.name, " err1_cycles"}, 32'(low_err), e.resp ? 32'd1 : 32'd0);
                     if (e.chk_rd) chk({e.name, " hrdata"}, hrdata_bus, e.rdata);
                  end
                  dphase = 1'b0;
               end
            end
            if (hsel && htrans[1] && hrdy_in) begin
               dphase  = 1'b1;
               waits   = 0;
               low_err = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      reset    = 1'b1;
      hsel     = 1'b0;
      htrans   = 2'b00;
      hwrite   = 1'b0;
      haddr    = 32'h0;
      hsize    = 3'b010;
      hprot    = 4'b0011;
      hwdata   = 32'h0;
      sel      = 1'b0;
      hold_low = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk1("reset hready_out ws1", hready1, 1'b1);
      chk1("reset hresp ws1", hresp1, 1'b0);
      chk("reset hrdata ws1", hrdata1, 32'h0);
      chk1("reset hready_out ws0", hready0, 1'b1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of a write's wait state.
      xfer("rst_wr", 1'b1, 32'h40, 3'b010, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 32'h0, 1'b0);
      #2;
      chk1("mid-wait hready_out", hready1, 1'b0);
      reset = 1'b1;
      #1;
      chk1("async reset hready_out", hready1, 1'b1);
      chk("async reset hrdata", hrdata1, 32'h0);
      chk1("async reset hresp", hresp1, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd("rd_after_rst", 32'h40, 3'b010, 32'h0000_0000, 1);

      // WAIT_STATES=1 instance: word, byte and halfword lanes.
      wr("wr_dead", 32'h10, 3'b010, 32'hDEAD_BEEF, 1);
      rd("rd_dead", 32'h10, 3'b010, 32'hDEAD_BEEF, 1);
      wr("wr_zero", 32'h10, 3'b010, 32'h0000_0000, 1);
      wr("wr_byte1", 32'h11, 3'b000, 32'hAAAA_AAAA, 1);
      wr("wr_half_hi", 32'h12, 3'b001, 32'h5566_5566, 1);
      rd("rd_merge", 32'h10, 3'b010, 32'h5566_AA00, 1);
      wr("wr_byte3", 32'h17, 3'b000, 32'h3C3C_3C3C, 1);
      wr("wr_half_lo", 32'h14, 3'b001, 32'h1234_1234, 1);
      rd("rd_merge2", 32'h14, 3'b010, 32'h3C00_1234, 1);
      repeat (3) @(posedge clk);
      #1;

      // WAIT_STATES=0 instance: back-to-back and error responses.
      sel = 1'b1;
      wr("wr0_b2b", 32'h20, 3'b010, 32'h1234_5678, 0);
      rd("rd0_b2b", 32'h20, 3'b010, 32'h1234_5678, 0);
      err("err_misaligned_word", 1'b1, 32'h22, 3'b010);
      rd("rd0_after_err", 32'h20, 3'b010, 32'h1234_5678, 0);
      err("err_out_of_range", 1'b0, 32'h400, 3'b010);
      err("err_odd_half", 1'b0, 32'h21, 3'b001);
      err("err_bad_size", 1'b0, 32'h24, 3'b011);
      wr("wr0_last", 32'h3FC, 3'b010, 32'hA5C3_0F96, 0);
      rd("rd0_last", 32'h3FC, 3'b010, 32'hA5C3_0F96, 0);
      repeat (3) @(posedge clk);
      #1;

      // IDLE, BUSY and a stalled bus must not capture anything.
      sel    = 1'b0;
      hsel   = 1'b1;
      hwrite = 1'b1;
      haddr  = 32'h10;
      hsize  = 3'b010;
      hwdata = 32'hFFFF_FFFF;
      htrans = 2'b00;
      repeat (2) begin
         @(negedge clk);
         chk1("idle hready_out", hready1, 1'b1);
         chk1("idle hresp", hresp1, 1'b0);
      end
      @(posedge clk);
      #1;
      htrans = 2'b01;
      repeat (2) begin
         @(negedge clk);
         chk1("busy hready_out", hready1, 1'b1);
         chk1("busy hresp", hresp1, 1'b0);
      end
      @(posedge clk);
      #1;
      htrans   = 2'b10;
      hold_low = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk1("stalled bus hready_out", hready1, 1'b1);
         chk1("stalled bus hresp", hresp1, 1'b0);
      end
      @(posedge clk);
      #1;
      hsel     = 1'b0;
      htrans   = 2'b00;
      hwrite   = 1'b0;
      hold_low = 1'b0;
      @(negedge clk);
      chk1("no capture hready_out", hready1, 1'b1);
      @(posedge clk);
      #1;
      rd("rd_unchanged", 32'h10, 3'b010, 32'h5566_AA00, 1);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
